// File: rtl/odd_fwd_unit.sv
// Odd-pipe result forwarding: tracks in-flight result valids for stages 2..7,
// resolves three source operands with youngest-stage priority, and drives retire.
// Optional hit statistics counter when ODD_FWD_STATS_EN is defined.
module odd_fwd_unit #(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rt_wr_en_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s2_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s3_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s4_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s5_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s6_op,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s7_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s2_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s3_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s4_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s5_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s6_op,
    input  logic [REG_DATA_WD-1:0] rf_data_s7_op,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_WD-1:0] ra_addr,
    input  logic [REG_ADDR_WD-1:0] rb_addr,
    input  logic [REG_ADDR_WD-1:0] rc_addr,
    input  logic [REG_DATA_WD-1:0] ra_rf,
    input  logic [REG_DATA_WD-1:0] rb_rf,
    input  logic [REG_DATA_WD-1:0] rc_rf,
    output logic [REG_DATA_WD-1:0] ra_fwd,
    output logic [REG_DATA_WD-1:0] rb_fwd,
    output logic [REG_DATA_WD-1:0] rc_fwd,
    output logic [2:0]             fwd_hit,
    output logic                   rf_wr_en,
    output logic [REG_ADDR_WD-1:0] rf_wr_addr,
    output logic [REG_DATA_WD-1:0] rf_wr_data
`ifdef ODD_FWD_STATS_EN
    ,
    output logic [31:0]            fwd_hit_cnt
`endif
);

    logic [7:2]             v_q, v_d;
    logic [REG_ADDR_WD-1:0] st_addr [2:7];
    logic [REG_DATA_WD-1:0] st_data [2:7];
    logic [REG_ADDR_WD-1:0] op_addr [3];
    logic [REG_DATA_WD-1:0] op_rf   [3];
    logic [REG_DATA_WD-1:0] fwd_q   [3];
    logic [REG_DATA_WD-1:0] fwd_d   [3];
    logic [REG_DATA_WD-1:0] sel_data [3];
    logic [2:0]             sel_hit;
    logic [2:0]             hit_q, hit_d;

    assign st_addr[2] = rf_addr_s2_op;
    assign st_addr[3] = rf_addr_s3_op;
    assign st_addr[4] = rf_addr_s4_op;
    assign st_addr[5] = rf_addr_s5_op;
    assign st_addr[6] = rf_addr_s6_op;
    assign st_addr[7] = rf_addr_s7_op;
    assign st_data[2] = rf_data_s2_op;
    assign st_data[3] = rf_data_s3_op;
    assign st_data[4] = rf_data_s4_op;
    assign st_data[5] = rf_data_s5_op;
    assign st_data[6] = rf_data_s6_op;
    assign st_data[7] = rf_data_s7_op;

    assign op_addr[0] = ra_addr;
    assign op_addr[1] = rb_addr;
    assign op_addr[2] = rc_addr;
    assign op_rf[0]   = ra_rf;
    assign op_rf[1]   = rb_rf;
    assign op_rf[2]   = rc_rf;

    // Flush squashes stages 2..4 as they advance; older stages keep retiring.
    always_comb begin
        v_d    = {v_q[6:2], rt_wr_en_op};
        if (flush) begin
            v_d[2] = 1'b0;
            v_d[3] = 1'b0;
            v_d[4] = 1'b0;
            v_d[5] = 1'b0;
        end
    end

    // Scan oldest to youngest so the youngest matching stage ends up selected.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sel_data[i] = op_rf[i];
            sel_hit[i]  = 1'b0;
            for (int k = 7; k >= 2; k--) begin
                if (v_q[k] && (st_addr[k] == op_addr[i])) begin
                    sel_data[i] = st_data[k];
                    sel_hit[i]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fwd_d[i] = fwd_q[i];
        end
        hit_d = hit_q;
        if (issue_valid) begin
            for (int i = 0; i < 3; i++) begin
                fwd_d[i] = sel_data[i];
            end
            hit_d = sel_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            hit_q <= '0;
            for (int i = 0; i < 3; i++) begin
                fwd_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            hit_q <= hit_d;
            for (int i = 0; i < 3; i++) begin
                fwd_q[i] <= fwd_d[i];
            end
        end
    end

    assign ra_fwd     = fwd_q[0];
    assign rb_fwd     = fwd_q[1];
    assign rc_fwd     = fwd_q[2];
    assign fwd_hit    = hit_q;
    assign rf_wr_en   = v_q[7];
    assign rf_wr_addr = rf_addr_s7_op;
    assign rf_wr_data = rf_data_s7_op;

`ifdef ODD_FWD_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [1:0]  hit_pop;
    logic [32:0] hit_sum;

    always_comb begin
        hit_pop   = {1'b0, sel_hit[0]} + {1'b0, sel_hit[1]} + {1'b0, sel_hit[2]};
        hit_sum   = {1'b0, hit_cnt_q} + {31'b0, hit_pop};
        hit_cnt_d = hit_cnt_q;
        if (issue_valid) begin
            hit_cnt_d = hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign fwd_hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_odd_fwd_unit.sv
// Scoreboard bench for odd_fwd_unit: in-flight writes are modelled as a list of
// ages, lookups are resolved from that list and queued; a negedge monitor checks.
module tb_odd_fwd_unit;
    localparam int AW = 7;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst, rt_wr_en_op, flush, issue_valid;
    logic [AW-1:0] s_addr [2:7];
    logic [DW-1:0] s_data [2:7];
    logic [AW-1:0] ra_addr, rb_addr, rc_addr;
    logic [DW-1:0] ra_rf, rb_rf, rc_rf;
    logic [DW-1:0] ra_fwd, rb_fwd, rc_fwd;
    logic [2:0]    fwd_hit;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
`ifdef ODD_FWD_STATS_EN
    logic [31:0]   fwd_hit_cnt;
`endif

    always #5 clk = ~clk;

    odd_fwd_unit #(.REG_ADDR_WD(AW), .REG_DATA_WD(DW)) dut (
        .clk(clk), .rst(rst), .rt_wr_en_op(rt_wr_en_op),
        .rf_addr_s2_op(s_addr[2]), .rf_addr_s3_op(s_addr[3]), .rf_addr_s4_op(s_addr[4]),
        .rf_addr_s5_op(s_addr[5]), .rf_addr_s6_op(s_addr[6]), .rf_addr_s7_op(s_addr[7]),
        .rf_data_s2_op(s_data[2]), .rf_data_s3_op(s_data[3]), .rf_data_s4_op(s_data[4]),
        .rf_data_s5_op(s_data[5]), .rf_data_s6_op(s_data[6]), .rf_data_s7_op(s_data[7]),
        .flush(flush), .issue_valid(issue_valid),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .ra_rf(ra_rf), .rb_rf(rb_rf), .rc_rf(rc_rf),
        .ra_fwd(ra_fwd), .rb_fwd(rb_fwd), .rc_fwd(rc_fwd), .fwd_hit(fwd_hit),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
`ifdef ODD_FWD_STATS_EN
        , .fwd_hit_cnt(fwd_hit_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [2:0]    hit;
    } exp_t;

    exp_t exp_q[$];
    int   ages[$];
    bit   prev_wr = 0, prev_flush = 0, prev_rst = 1;
    int   n_cmp = 0, n_fail = 0;

    function automatic bit has_age(input int k);
        foreach (ages[i]) if (ages[i] == k) return 1;
        return 0;
    endfunction

    function automatic void lookup(input logic [AW-1:0] a, input logic [DW-1:0] rfv,
                                   output logic [DW-1:0] d, output logic h);
        d = rfv;
        h = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            if (!h && has_age(k) && s_addr[k] == a) begin
                d = s_data[k];
                h = 1'b1;
            end
        end
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock and age the in-flight writes by what was driven last cycle.
    task automatic advance();
        int nq[$];
        @(posedge clk);
        #1;
        if (prev_rst) begin
            ages.delete();
        end else begin
            foreach (ages[i]) begin
                if (prev_flush && ages[i] <= 4) continue;
                if (ages[i] + 1 <= 7) nq.push_back(ages[i] + 1);
            end
            if (prev_wr && !prev_flush) nq.push_back(2);
            ages = nq;
        end
    endtask

    task automatic rand_inputs();
        for (int k = 2; k <= 7; k++) begin
            s_addr[k] = AW'($urandom_range(0, 7));
            s_data[k] = rnd_data();
        end
        rt_wr_en_op = 1'($urandom_range(0, 1));
        flush       = ($urandom_range(0, 9) == 0);
        issue_valid = ($urandom_range(0, 9) < 6);
        rst         = ($urandom_range(0, 99) == 0);
        ra_addr = AW'($urandom_range(0, 7));
        rb_addr = AW'($urandom_range(0, 7));
        rc_addr = AW'($urandom_range(0, 7));
        ra_rf = rnd_data();
        rb_rf = rnd_data();
        rc_rf = rnd_data();
    endtask

    task automatic idle_inputs();
        rand_inputs();
        rt_wr_en_op = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic commit();
        exp_t e;
        logic h;
        if (issue_valid && !rst) begin
            lookup(ra_addr, ra_rf, e.a, h); e.hit[0] = h;
            lookup(rb_addr, rb_rf, e.b, h); e.hit[1] = h;
            lookup(rc_addr, rc_rf, e.c, h); e.hit[2] = h;
            exp_q.push_back(e);
        end
        prev_wr    = rt_wr_en_op;
        prev_flush = flush;
        prev_rst   = rst;
    endtask

    task automatic idle_cycle();
        advance(); idle_inputs(); commit();
    endtask

    // Monitor: outputs reflect the last lookup (or zeros after reset) and retire state.
    bit   mon_en = 0, issue_dly = 0, rst_dly = 0;
    exp_t last_exp = '{a: '0, b: '0, c: '0, hit: '0};
    logic [31:0] cnt_exp = 0;

    always @(posedge clk) begin
        mon_en    <= mon_en | rst;
        rst_dly   <= rst;
        issue_dly <= issue_valid && !rst;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_dly) begin
                last_exp = '{a: '0, b: '0, c: '0, hit: '0};
                cnt_exp  = 0;
            end else if (issue_dly) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    for (int i = 0; i < 3; i++)
                        if (last_exp.hit[i] && cnt_exp != 32'hFFFF_FFFF) cnt_exp++;
                end
            end
            check("ra_fwd", ra_fwd, last_exp.a);
            check("rb_fwd", rb_fwd, last_exp.b);
            check("rc_fwd", rc_fwd, last_exp.c);
            check("fwd_hit", DW'(fwd_hit), DW'(last_exp.hit));
            check("rf_wr_en", DW'(rf_wr_en), DW'(has_age(7)));
            if (has_age(7)) begin
                check("rf_wr_addr", DW'(rf_wr_addr), DW'(s_addr[7]));
                check("rf_wr_data", rf_wr_data, s_data[7]);
            end
`ifdef ODD_FWD_STATS_EN
            check("fwd_hit_cnt", DW'(fwd_hit_cnt), DW'(cnt_exp));
`endif
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance(); idle_inputs(); rst = 1'b1; commit();
        end
        idle_cycle();

        // Write to r5, then look r5 up while the write sits in stage 3.
        advance(); idle_inputs(); rt_wr_en_op = 1'b1; s_addr[2] = 5;
        s_data[2] = {DW/8{8'hAA}}; commit();
        advance(); idle_inputs(); issue_valid = 1'b1; ra_addr = 5; s_addr[3] = 5;
        s_data[3] = {DW/8{8'hAA}}; commit();
        for (int c = 0; c < 7; c++) idle_cycle();

        // Two writes to r9 concurrently in stages 3 and 6: stage 3 must win.
        for (int c = 0; c < 6; c++) begin
            advance(); idle_inputs();
            rt_wr_en_op = (c == 0 || c == 3);
            if (c == 5) begin
                issue_valid = 1'b1; rb_addr = 9;
                s_addr[3] = 9; s_data[3] = DW'(8'h33);
                s_addr[6] = 9; s_data[6] = DW'(8'h66);
            end
            commit();
        end
        for (int c = 0; c < 7; c++) idle_cycle();

        // Write flushed in stage 3 never retires; lookup falls back to rf.
        for (int c = 0; c < 10; c++) begin
            advance(); idle_inputs();
            for (int k = 2; k <= 7; k++) s_addr[k] = 3;
            rt_wr_en_op = (c == 0);
            flush       = (c == 2);
            issue_valid = (c == 4);
            ra_addr = 3; rb_addr = 3; rc_addr = 3;
            commit();
        end

        // Single write followed by an idle pipe: retires exactly once.
        for (int c = 0; c < 9; c++) begin
            advance(); idle_inputs(); rt_wr_en_op = (c == 0); commit();
        end

        // Back-to-back writes with reset mid-flight, then a lookup of all stages.
        for (int c = 0; c < 12; c++) begin
            advance(); idle_inputs();
            for (int k = 2; k <= 7; k++) s_addr[k] = 4;
            rt_wr_en_op = (c < 6);
            rst         = (c == 4);
            issue_valid = (c == 6 || c == 3);
            ra_addr = 4; rb_addr = 4; rc_addr = 4;
            commit();
        end

        for (int c = 0; c < 3000; c++) begin
            advance(); rand_inputs(); commit();
        end
        for (int c = 0; c < 10; c++) idle_cycle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/odd_fwd_unit.md
ODD_FWD_UNIT -- requirements
Module: odd_fwd_unit

Interface
REQ-001 Parameter REG_ADDR_WD, default 7: register address width.
REQ-002 Parameter REG_DATA_WD, default 128: register data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rt_wr_en_op  input  1  odd-pipe result-write qualifier; enters the valid tracker at stage 2.
REQ-006 rf_addr_s2_op..rf_addr_s7_op  input  REG_ADDR_WD each  destination address per odd-pipe stage 2..7.
REQ-007 rf_data_s2_op..rf_data_s7_op  input  REG_DATA_WD each  result data per odd-pipe stage 2..7.
REQ-008 flush  input  1  squash in-flight results in stages 2..4.
REQ-009 issue_valid  input  1  operand lookup request this cycle.
REQ-010 ra_addr, rb_addr, rc_addr  input  REG_ADDR_WD each  source operand addresses.
REQ-011 ra_rf, rb_rf, rc_rf  input  REG_DATA_WD each  register-file read values for those addresses.
REQ-012 ra_fwd, rb_fwd, rc_fwd  output  REG_DATA_WD each  resolved operands, registered.
REQ-013 fwd_hit  output  3  per-operand forward-hit flags {rc,rb,ra}, registered.
REQ-014 rf_wr_en  output  1  retire write enable to register file.
REQ-015 rf_wr_addr  output  REG_ADDR_WD  retire address (= rf_addr_s7_op).
REQ-016 rf_wr_data  output  REG_DATA_WD  retire data (= rf_data_s7_op).

Function
REQ-017 Unit SHALL hold a 6-bit valid shift register v[2..7]; each cycle v[2] <= rt_wr_en_op, v[k] <= v[k-1] for k=3..7.
REQ-018 flush=1 SHALL clear v[3..5] at the edge (stages 2..4 shifting forward) and force v[2] <= 0 regardless of rt_wr_en_op; v[6], v[7] shift normally.
REQ-019 Stage k SHALL be a forward candidate for operand X iff v[k]=1 and rf_addr_sk_op == X_addr, evaluated on the current-cycle inputs.
REQ-020 Multiple candidates: lowest stage index (youngest) SHALL win; s2 > s3 > ... > s7.
REQ-021 No candidate: operand SHALL take X_rf; corresponding fwd_hit bit = 0.
REQ-022 Latency: lookup with issue_valid=1 in cycle N SHALL appear on X_fwd/fwd_hit in cycle N+1.
REQ-023 issue_valid=0: X_fwd and fwd_hit SHALL hold previous values.
REQ-024 ra/rb/rc resolution SHALL be independent; same address on two operands yields identical results.
REQ-025 rf_wr_en SHALL equal v[7] (registered state, no combinational path from inputs); rf_wr_addr/rf_wr_data pass stage-7 inputs through.
REQ-026 Stage-7 candidate SHALL forward in the same cycle it retires (no gap between forward and register-file visibility).
REQ-027 flush in the same cycle as issue_valid: lookup SHALL use pre-flush v[] values.

Reset
REQ-028 rst=1 SHALL clear v[2..7], ra_fwd, rb_fwd, rc_fwd, fwd_hit to 0; rf_wr_en SHALL be 0 in the cycle after rst.
REQ-029 rst SHALL override flush, issue_valid and rt_wr_en_op; in-flight results at reset are discarded, never retired.
REQ-030 First lookup after rst release SHALL return register-file values (no stale hits).

Configuration
REQ-031 Macro ODD_FWD_STATS_EN defined: unit SHALL add output fwd_hit_cnt (32 bits), incremented by popcount of new fwd_hit on each issue_valid cycle, saturating at 0xFFFFFFFF, cleared by rst.
REQ-032 Macro undefined: no counter logic and no fwd_hit_cnt port; all other behaviour identical.

Verification
REQ-033 rt_wr_en_op=1, rf_addr_s2_op=5, data 0xAA..AA; next cycle issue ra_addr=5, rf_addr_s3_op=5 -> cycle after: ra_fwd=0xAA..AA, fwd_hit=3'b001.
REQ-034 v[3] and v[6] both valid with addr 9 (data 0x33, 0x66); issue rb_addr=9 -> rb_fwd=0x33, fwd_hit[1]=1.
REQ-035 Write issued, flush asserted while it is in stage 3 -> rf_wr_en never asserts for it; lookup of its address returns X_rf.
REQ-036 Single write at cycle 0 -> rf_wr_en=1 exactly in cycle 6 with rf_wr_addr/rf_wr_data = stage-7 inputs; 0 otherwise.
REQ-037 Six back-to-back writes, rst asserted mid-flight -> rf_wr_en=0 thereafter, fwd outputs 0, next lookup fwd_hit=3'b000.
REQ-038 With ODD_FWD_STATS_EN: issue ra=rb=rc=5 with stage hit -> fwd_hit=3'b111, fwd_hit_cnt increments by 3.
